// File: rtl/rf_wb_arbiter.sv
// Round-robin arbiter sharing the integer regfile write port between the ALU (req 0)
// and LSU/MDU (req 1) write-back paths, plus a pending-write scoreboard for RAW stalls.
module rf_wb_arbiter #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  wb0_valid,
    output logic                  wb0_ready,
    input  logic [ADDR_WIDTH-1:0] wb0_addr,
    input  logic [DATA_WIDTH-1:0] wb0_data,

    input  logic                  wb1_valid,
    output logic                  wb1_ready,
    input  logic [ADDR_WIDTH-1:0] wb1_addr,
    input  logic [DATA_WIDTH-1:0] wb1_data,

    output logic                  rf_wen,
    output logic [ADDR_WIDTH-1:0] rf_waddr,
    output logic [DATA_WIDTH-1:0] rf_wdata,

    input  logic                  sb_set_en,
    input  logic [ADDR_WIDTH-1:0] sb_set_addr,
    input  logic [ADDR_WIDTH-1:0] rs1_addr,
    input  logic [ADDR_WIDTH-1:0] rs2_addr,
    output logic                  rs1_busy,
    output logic                  rs2_busy,
    output logic                  sb_err
);

    localparam int NREG = 1 << ADDR_WIDTH;

    // last = 1 means requester 1 won the most recent transfer, so requester 0 wins a tie.
    logic                  last;
    logic                  gnt0_p0;
    logic                  gnt1_p0;
    logic                  xfer_p0;
    logic [ADDR_WIDTH-1:0] waddr_p0;
    logic [DATA_WIDTH-1:0] wdata_p0;

    logic                  vld_p1;
    logic [ADDR_WIDTH-1:0] waddr_p1;
    logic [DATA_WIDTH-1:0] wdata_p1;

    logic [NREG-1:0]       pend;
    logic [NREG-1:0]       pend_nxt;
    logic                  err_hit;
    logic                  err_q;

    function automatic logic [1:0] rr_grant(input logic v0, input logic v1, input logic lst);
        logic [1:0] g;
        g[0] = v0 && (!v1 || lst);
        g[1] = v1 && (!v0 || !lst);
        return g;
    endfunction

    // Stage p0: combinational arbitration and winner mux
    always_comb begin
        logic [1:0] g;
        g        = rr_grant(wb0_valid, wb1_valid, last);
        gnt0_p0  = g[0];
        gnt1_p0  = g[1];
        xfer_p0  = g[0] | g[1];
        waddr_p0 = g[1] ? wb1_addr : wb0_addr;
        wdata_p0 = g[1] ? wb1_data : wb0_data;
    end

    assign wb0_ready = gnt0_p0;
    assign wb1_ready = gnt1_p0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last <= 1'b1;
        end else if (xfer_p0) begin
            last <= gnt1_p0;
        end
    end

    // Stage p1: registered regfile write port; x0 writes are accepted but never enabled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1   <= 1'b0;
            waddr_p1 <= '0;
            wdata_p1 <= '0;
        end else begin
            vld_p1 <= xfer_p0 && (waddr_p0 != '0);
            if (xfer_p0) begin
                waddr_p1 <= waddr_p0;
                wdata_p1 <= wdata_p0;
            end
        end
    end

    assign rf_wen   = vld_p1;
    assign rf_waddr = waddr_p1;
    assign rf_wdata = wdata_p1;

    // Scoreboard: clear on the commit edge, set wins over a same-edge clear.
    always_comb begin
        pend_nxt = '0;
        err_hit  = 1'b0;
        for (int i = 1; i < NREG; i++) begin
            logic set_i;
            logic clr_i;
            set_i       = sb_set_en && (sb_set_addr == ADDR_WIDTH'(i));
            clr_i       = vld_p1 && (waddr_p1 == ADDR_WIDTH'(i));
            pend_nxt[i] = set_i | (pend[i] & ~clr_i);
            if (set_i && pend[i] && !clr_i) begin
                err_hit = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend  <= '0;
            err_q <= 1'b0;
        end else begin
            pend  <= pend_nxt;
            err_q <= err_q | err_hit;
        end
    end

    assign sb_err   = err_q;
    assign rs1_busy = pend[rs1_addr];
    assign rs2_busy = pend[rs2_addr];

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter: arbitration order, write latency, x0 handling,
// scoreboard set/clear/error behaviour and asynchronous reset.
module tb_rf_wb_arbiter;

    localparam int AW = 5;
    localparam int DW = 64;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          wb0_valid = 1'b0, wb1_valid = 1'b0;
    logic          wb0_ready, wb1_ready;
    logic [AW-1:0] wb0_addr = '0, wb1_addr = '0;
    logic [DW-1:0] wb0_data = '0, wb1_data = '0;
    logic          rf_wen;
    logic [AW-1:0] rf_waddr;
    logic [DW-1:0] rf_wdata;
    logic          sb_set_en = 1'b0;
    logic [AW-1:0] sb_set_addr = '0;
    logic [AW-1:0] rs1_addr = '0, rs2_addr = '0;
    logic          rs1_busy, rs2_busy, sb_err;

    int n_chk = 0;
    int n_err = 0;

    rf_wb_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .wb0_valid(wb0_valid), .wb0_ready(wb0_ready), .wb0_addr(wb0_addr), .wb0_data(wb0_data),
        .wb1_valid(wb1_valid), .wb1_ready(wb1_ready), .wb1_addr(wb1_addr), .wb1_data(wb1_data),
        .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .sb_set_en(sb_set_en), .sb_set_addr(sb_set_addr),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_busy(rs1_busy), .rs2_busy(rs2_busy), .sb_err(sb_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        #1;
    endtask

    initial begin
        logic [1:0] exp_gnt [4];
        logic [AW-1:0] exp_wa [4];
        exp_gnt = '{2'b01, 2'b10, 2'b01, 2'b10};
        exp_wa  = '{5'd1, 5'd2, 5'd1, 5'd2};

        // Reset state
        #2 rst_n = 1'b0;
        #1;
        check("rst_wen", rf_wen, 0);
        check("rst_waddr", rf_waddr, 0);
        check("rst_wdata", rf_wdata, 0);
        check("rst_err", sb_err, 0);
        wb1_valid = 1'b1;
        #1;
        check("rst_ready1", wb1_ready, 1);
        wb1_valid = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();

        // Single write from requester 0
        wb0_valid = 1'b1; wb0_addr = 5; wb0_data = 64'h1234;
        #1;
        check("t1_ready0", wb0_ready, 1);
        check("t1_ready1", wb1_ready, 0);
        step();
        wb0_valid = 1'b0;
        check("t1_wen", rf_wen, 1);
        check("t1_waddr", rf_waddr, 5);
        check("t1_wdata", rf_wdata, 64'h1234);
        step();
        check("t1_wen_off", rf_wen, 0);
        check("t1_waddr_hold", rf_waddr, 5);

        // Continuous contention from reset alternates 0,1,0,1
        pulse_reset();
        wb0_valid = 1'b1; wb0_addr = 1; wb0_data = 64'h11;
        wb1_valid = 1'b1; wb1_addr = 2; wb1_data = 64'h22;
        for (int i = 0; i < 4; i++) begin
            #1;
            check($sformatf("t2_gnt%0d", i), {wb1_ready, wb0_ready}, exp_gnt[i]);
            step();
            check($sformatf("t2_wa%0d", i), rf_waddr, exp_wa[i]);
            check($sformatf("t2_wd%0d", i), rf_wdata, (exp_wa[i] == 1) ? 64'h11 : 64'h22);
        end
        wb0_valid = 1'b0; wb1_valid = 1'b0;
        step();

        // Scoreboard busy until the write to r7 commits
        rs1_addr = 7;
        sb_set_en = 1'b1; sb_set_addr = 7;
        #1;
        check("t3_busy_pre", rs1_busy, 0);
        step();
        sb_set_en = 1'b0;
        check("t3_busy_set", rs1_busy, 1);
        step();
        check("t3_busy_hold", rs1_busy, 1);
        wb1_valid = 1'b1; wb1_addr = 7; wb1_data = 64'h77;
        step();
        wb1_valid = 1'b0;
        check("t3_wen", rf_wen, 1);
        check("t3_waddr", rf_waddr, 7);
        check("t3_busy_commit_cyc", rs1_busy, 1);
        step();
        check("t3_busy_clear", rs1_busy, 0);

        // Same-edge set and clear of r9, then a genuine double set
        rs2_addr = 9;
        sb_set_en = 1'b1; sb_set_addr = 9;
        step();
        sb_set_en = 1'b0;
        check("t4_busy", rs2_busy, 1);
        wb0_valid = 1'b1; wb0_addr = 9; wb0_data = 64'h99;
        step();
        wb0_valid = 1'b0;
        check("t4_wen", rf_wen, 1);
        check("t4_waddr", rf_waddr, 9);
        sb_set_en = 1'b1; sb_set_addr = 9;
        step();
        check("t4_busy_setwins", rs2_busy, 1);
        check("t4_err_clear", sb_err, 0);
        step();
        sb_set_en = 1'b0;
        check("t4_err_set", sb_err, 1);
        step();
        check("t4_err_sticky", sb_err, 1);

        // x0 write and x0 scoreboard set
        rs1_addr = 0;
        wb1_valid = 1'b1; wb1_addr = 0; wb1_data = 64'hFFFF;
        sb_set_en = 1'b1; sb_set_addr = 0;
        #1;
        check("t5_ready1", wb1_ready, 1);
        step();
        wb1_valid = 1'b0; sb_set_en = 1'b0;
        check("t5_wen", rf_wen, 0);
        check("t5_busy0", rs1_busy, 0);

        // Asynchronous reset mid-cycle with a write and a pending bit in flight
        rs1_addr = 12;
        sb_set_en = 1'b1; sb_set_addr = 12;
        wb0_valid = 1'b1; wb0_addr = 3; wb0_data = 64'hABCD;
        step();
        sb_set_en = 1'b0; wb0_valid = 1'b0;
        check("t6_wen_pre", rf_wen, 1);
        check("t6_busy_pre", rs1_busy, 1);
        #2 rst_n = 1'b0;
        #1;
        check("t6_wen", rf_wen, 0);
        check("t6_waddr", rf_waddr, 0);
        check("t6_wdata", rf_wdata, 0);
        check("t6_busy", rs1_busy, 0);
        check("t6_busy9", rs2_busy, 0);
        check("t6_err", sb_err, 0);
        #1 rst_n = 1'b1;
        step();
        wb0_valid = 1'b1; wb1_valid = 1'b1;
        #1;
        check("t6_tie", {wb1_ready, wb0_ready}, 2'b01);
        step();
        wb0_valid = 1'b0; wb1_valid = 1'b0;
        check("t6_tie_waddr", rf_waddr, 3);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/rf_wb_arbiter.md
# rf_wb_arbiter

Shares the integer register file's single write port between two write-back requesters: the ALU path (requester 0) and the multi-cycle LSU/MDU path (requester 1). It arbitrates round-robin with valid/ready handshakes and registers the winning write into the regfile's `wen`/`waddr`/`wdata` port. It also keeps a 32-entry pending-write scoreboard, which the decode stage uses to stall on RAW hazards. It sits between the execute units and the regfile in the NPC core.

## Interface
- `ADDR_WIDTH`, 5, register index width (32 GPRs)
- `DATA_WIDTH`, 64, GPR data width
- `clk`  in  1  core clock, rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `wb0_valid`  in  1  requester 0 (ALU) has a write
- `wb0_ready`  out  1  requester 0 write accepted this cycle
- `wb0_addr`  in  ADDR_WIDTH  requester 0 destination reg
- `wb0_data`  in  DATA_WIDTH  requester 0 write data
- `wb1_valid`, `wb1_ready`, `wb1_addr`, `wb1_data`  same meaning for requester 1 (LSU/MDU)
- `rf_wen`  out  1  regfile write enable
- `rf_waddr`  out  ADDR_WIDTH  regfile write address
- `rf_wdata`  out  DATA_WIDTH  regfile write data
- `sb_set_en`  in  1  decode issued an instruction writing `sb_set_addr`
- `sb_set_addr`  in  ADDR_WIDTH  register to mark pending
- `rs1_addr`, `rs2_addr`  in  ADDR_WIDTH  decode source operands
- `rs1_busy`, `rs2_busy`  out  1  source has a pending write (combinational)
- `sb_err`  out  1  sticky: set issued to an already-pending register

## Operation
- Handshake: a transfer on requester k occurs in a cycle where `wbk_valid && wbk_ready`. `wbk_ready` is combinational from the valids and the arbitration state. The requester must hold addr/data stable while valid and not ready.
- Arbitration:
  - Only one valid: it is granted.
  - Both valid: grant the requester not granted most recently.
  - Register `last` updates only on a transfer.
  - At most one ready is high per cycle.
- Write stage: on a transfer, capture addr/data into the output registers and set `rf_wen`=1 for exactly the next cycle. With no transfer, `rf_wen`=0 and `rf_waddr`/`rf_wdata` hold their last values.
- x0: a transfer with addr 0 is accepted (ready asserted) but produces `rf_wen`=0.
- Scoreboard `pend[31:1]`, with `pend[0]` constant 0:
  - Set on `sb_set_en` with a nonzero addr.
  - Cleared at the edge where `rf_wen`=1 for `rf_waddr` (the same edge the regfile stores the data).
  - Same-cycle set and clear of the same register: set wins, so the register stays pending.
  - Set to a register already pending (and not being cleared that edge): the register stays pending and `sb_err` goes 1 until reset.
- `rsN_busy` = `pend[rsN_addr]`; always 0 for addr 0.

## Timing
- Reset values (asynchronous, on `rst_n`=0):
  - `rf_wen`=0, `rf_waddr`=0, `rf_wdata`=0
  - `pend`=0, `sb_err`=0
  - `last`=1, so requester 0 wins the first tie
  - `wbk_ready` follows the valids combinationally, even during reset
- Reset asserted mid-operation: any registered write not yet committed is dropped, and all pending bits clear.
- Latency:
  - Transfer at edge n-1 → `rf_wen` high in cycle n → data visible on the regfile's async read port in cycle n+1.
  - `rsN_busy` drops in cycle n+1, the same cycle the data becomes readable, so there is no stale-read window.
- Throughput: one write per cycle. Under continuous contention the requesters alternate, so neither starves.
- No internal buffering beyond the single output register. Backpressure is pure combinational `ready`.

## Test plan
- Reset, then `wb0_valid`=1, addr 5, data 0x1234 → `wb0_ready`=1 in the same cycle. Next cycle `rf_wen`=1, `rf_waddr`=5, `rf_wdata`=0x1234. The cycle after, `rf_wen`=0.
- Both valid for 4 consecutive cycles (wb0 addr 1, wb1 addr 2), starting from reset → grants go 0,1,0,1. `rf_waddr` sequence is 1,2,1,2. `wbk_ready` is never high for both requesters in one cycle.
- `sb_set_en` on addr 7; then, with `rs1_addr`=7, `rs1_busy`=1 until a write to 7 commits. Check `rs1_busy`=0 in the cycle after `rf_wen`=1/`rf_waddr`=7.
- Same-cycle set of addr 9 and commit to 9 (`rf_wen`=1, `rf_waddr`=9) → `pend[9]` stays 1 and `sb_err` stays 0. A second set of 9 while pending → `sb_err`=1, held until reset.
- wb1 transfer with addr 0, data 0xFFFF → `wb1_ready`=1 but `rf_wen`=0 next cycle. `sb_set_en` on addr 0 → `rs1_busy` stays 0 for `rs1_addr`=0.
- Assert `rst_n`=0 mid-cycle while `rf_wen`=1 and `pend` is nonzero → all outputs, `pend` and `sb_err` are 0 immediately. After release, the first tie is granted to requester 0.
